reg_mm_arbiter: RTL
===================

REG_MM_ARBITER -- requirements
Module: reg_mm_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 2, number of Avalon-MM masters sharing the register bus (2..8).
REQ-002 SHALL have parameter ADDR_W, default 16, Avalon-MM address width.
REQ-003 SHALL have parameter DATA_W, default 32, Avalon-MM data width.
REQ-004 SHALL have parameter RD_TIMEOUT, default 255, maximum cycles to wait for readdatavalid (1..65535).
REQ-005 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-007 SHALL have ports m_address/m_read/m_write/m_writedata  input  NUM_MASTERS x (ADDR_W/1/1/DATA_W)  per-master command.
REQ-008 SHALL have ports m_readdata/m_readdatavalid/m_waitrequest  output  NUM_MASTERS x (DATA_W/1/1)  per-master response.
REQ-009 SHALL have ports s_address/s_read/s_write/s_writedata  output  ADDR_W/1/1/DATA_W  command to the shared register slave.
REQ-010 SHALL have ports s_readdata/s_readdatavalid/s_waitrequest  input  DATA_W/1/1  slave response.
REQ-011 SHALL have port rd_timeout_err  output  1  one-cycle pulse when a read times out.

Function
REQ-012 SHALL implement states IDLE, ISSUE, WAIT_RD; one outstanding transaction only.
REQ-013 IDLE: master i requests when m_read[i] or m_write[i] is high; if any request, SHALL register grant index and command, go to ISSUE next cycle.
REQ-014 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod NUM_MASTERS; after reset last_grant = NUM_MASTERS-1 (master 0 first).
REQ-015 ISSUE: s_read/s_write SHALL equal the registered command and stay stable while s_waitrequest=1.
REQ-016 ISSUE, write accepted (s_waitrequest=0): SHALL drop m_waitrequest[grant] for exactly that cycle, go to IDLE.
REQ-017 ISSUE, read accepted: SHALL drop m_waitrequest[grant] that cycle, go to WAIT_RD, clear timeout counter.
REQ-018 WAIT_RD: on s_readdatavalid SHALL forward s_readdata to m_readdata[grant] with m_readdatavalid[grant]=1 in the same cycle (combinational), go to IDLE.
REQ-019 WAIT_RD: timeout counter increments each cycle; when it reaches RD_TIMEOUT without s_readdatavalid, SHALL return 32'hDEAD_BEEF (truncated/zero-extended to DATA_W) with m_readdatavalid[grant]=1, pulse rd_timeout_err, go to IDLE.
REQ-020 s_readdatavalid and timeout in the same cycle: real data SHALL win, no error pulse.
REQ-021 s_readdatavalid outside WAIT_RD SHALL be ignored.
REQ-022 m_waitrequest[i] SHALL be 1 for every master except the accepted-grant cycle in REQ-016/017; non-granted masters see m_readdatavalid=0.
REQ-023 Master asserting both read and write SHALL be treated as a write.
REQ-024 Minimum latency: request in IDLE at cycle N -> slave command at N+1 -> master released at N+1 if s_waitrequest=0; back-to-back throughput one write per 2 cycles.
REQ-025 s_read, s_write SHALL be 0 in IDLE and WAIT_RD.

Reset
REQ-026 With rst_n=0 at a clock edge, state SHALL become IDLE, last_grant NUM_MASTERS-1, timeout counter 0.
REQ-027 During and after reset: s_read=0, s_write=0, s_address=0, s_writedata=0, m_waitrequest all 1, m_readdatavalid all 0, m_readdata all 0, rd_timeout_err=0.
REQ-028 Reset mid-transaction SHALL abandon it without response; late s_readdatavalid after reset SHALL be ignored.

Structure
REQ-029 State enum and DEADBEEF constant SHALL live in shared package reg_mm_pkg.
REQ-030 Round-robin grant logic SHALL be sub-module rr_arbiter (parameter N; inputs req, last_grant; outputs grant index, grant_valid).

Verification
REQ-031 Single write: master 0 writes addr 0x0004 data 0x1234_5678, s_waitrequest=0 -> s_write one cycle with those values, m_waitrequest[0] low one cycle.
REQ-032 Contention: masters 0 and 1 write continuously -> slave sees alternating grants 0,1,0,1 across 8 transactions, starting with 0.
REQ-033 Read with 3-cycle slave latency returning 0xCAFE_0001 to master 1 -> m_readdatavalid[1] high one cycle with 0xCAFE_0001; master 0 sees no valid.
REQ-034 Slave stalls with s_waitrequest=1 for 5 cycles -> s_address/s_writedata stable for all 6 cycles, single acceptance.
REQ-035 Read with no s_readdatavalid, RD_TIMEOUT=255 -> after 255 WAIT_RD cycles m_readdata=0xDEAD_BEEF, rd_timeout_err pulses once, next request served.
REQ-036 rst_n low during WAIT_RD, then s_readdatavalid -> no m_readdatavalid, outputs at reset values, master 0 granted first afterwards.

Source files
------------

// File: rtl/reg_mm_pkg.sv
// rtl/reg_mm_pkg.sv - shared types and constants for the register-bus arbiter
package reg_mm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } state_t;

  // Read data returned to a master whose read was never answered by the slave.
  localparam logic [31:0] DEADBEEF = 32'hDEAD_BEEF;

  localparam int TIMER_W = 16;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin pick starting one past the last granted index
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [IW-1:0] grant,
  output logic          grant_valid
);

  int idx;

  // Walk from the farthest candidate back to the nearest so the nearest requester wins.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int k = N; k >= 1; k--) begin
      idx = int'(last_grant) + k;
      if (idx >= N) idx = idx - N;
      if (req[idx]) begin
        grant       = IW'(idx);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_mm_arbiter.sv
// rtl/reg_mm_arbiter.sv - shares one Avalon-MM register slave among several masters,
// one outstanding transaction at a time, with a read-response timeout.
module reg_mm_arbiter
  import reg_mm_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int RD_TIMEOUT  = 255
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_MASTERS-1:0][ADDR_W-1:0]  m_address,
  input  logic [NUM_MASTERS-1:0]              m_read,
  input  logic [NUM_MASTERS-1:0]              m_write,
  input  logic [NUM_MASTERS-1:0][DATA_W-1:0]  m_writedata,
  output logic [NUM_MASTERS-1:0][DATA_W-1:0]  m_readdata,
  output logic [NUM_MASTERS-1:0]              m_readdatavalid,
  output logic [NUM_MASTERS-1:0]              m_waitrequest,
  output logic [ADDR_W-1:0]                   s_address,
  output logic                                s_read,
  output logic                                s_write,
  output logic [DATA_W-1:0]                   s_writedata,
  input  logic [DATA_W-1:0]                   s_readdata,
  input  logic                                s_readdatavalid,
  input  logic                                s_waitrequest,
  output logic                                rd_timeout_err
);

  localparam int IW = $clog2(NUM_MASTERS);
  localparam logic [DATA_W-1:0]  TIMEOUT_DATA = DATA_W'(DEADBEEF);
  localparam logic [TIMER_W-1:0] TIMER_LIMIT  = TIMER_W'(RD_TIMEOUT);

  state_t               state;
  logic [IW-1:0]        grant_q;
  logic [IW-1:0]        last_grant;
  logic [IW-1:0]        rr_grant;
  logic                 rr_valid;
  logic [TIMER_W-1:0]   timer;
  logic                 rd_expired;
  logic                 accept;
  logic                 rd_data;
  logic                 rd_tmo;

  rr_arbiter #(.N(NUM_MASTERS), .IW(IW)) u_rr (
    .req         (m_read | m_write),
    .last_grant  (last_grant),
    .grant       (rr_grant),
    .grant_valid (rr_valid)
  );

  assign rd_expired = (timer == TIMER_LIMIT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_grant  <= IW'(NUM_MASTERS - 1);
      grant_q     <= '0;
      timer       <= '0;
      s_read      <= 1'b0;
      s_write     <= 1'b0;
      s_address   <= '0;
      s_writedata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rr_valid) begin
            grant_q     <= rr_grant;
            last_grant  <= rr_grant;
            // A master raising both strobes is served as a write.
            s_write     <= m_write[rr_grant];
            s_read      <= !m_write[rr_grant];
            s_address   <= m_address[rr_grant];
            s_writedata <= m_writedata[rr_grant];
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (!s_waitrequest) begin
            s_read  <= 1'b0;
            s_write <= 1'b0;
            timer   <= '0;
            state   <= s_read ? WAIT_RD : IDLE;
          end
        end
        WAIT_RD: begin
          if (s_readdatavalid || rd_expired) state <= IDLE;
          else                               timer <= timer + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Responses are combinational so a master is released in the acceptance cycle itself;
  // gating with rst_n keeps them quiet while reset is held.
  always_comb begin
    accept         = rst_n && (state == ISSUE) && !s_waitrequest;
    rd_data        = rst_n && (state == WAIT_RD) && s_readdatavalid;
    rd_tmo         = rst_n && (state == WAIT_RD) && !s_readdatavalid && rd_expired;
    rd_timeout_err = rd_tmo;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      m_waitrequest[i]   = 1'b1;
      m_readdatavalid[i] = 1'b0;
      m_readdata[i]      = '0;
      if (grant_q == IW'(i)) begin
        m_waitrequest[i]   = !accept;
        m_readdatavalid[i] = rd_data || rd_tmo;
        if (rd_data)     m_readdata[i] = s_readdata;
        else if (rd_tmo) m_readdata[i] = TIMEOUT_DATA;
      end
    end
  end

endmodule
